// File: rtl/fltadd_sequencer.sv
// fltadd_sequencer
//   Hardware sequencer for the half-precision float add. On start it reads
//   operands A and B, low byte first, over an 8-bit memory port. It then
//   aligns B to A's exponent and adds the two. The sum is normalised and
//   truncated, then written back low byte first, and done is raised. Only
//   same-sign addition is handled and no rounding is done. The result takes
//   the sign of A as read from memory.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        begin one add (honoured only in IDLE or DONE)
//   done         high while the FSM sits in DONE
//   mem_addr     memory byte address (combinational from state)
//   mem_rd_data  read data for mem_addr, valid in the same cycle
//   mem_wr_data  write data
//   mem_wr_en    write strobe, memory captures on the clk edge
module fltadd_sequencer #(
    parameter int OP_A_ADDR = 8,
    parameter int OP_B_ADDR = 10,
    parameter int RES_ADDR  = 12,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    mem_wr_data,
    output logic          mem_wr_en
);

    localparam logic [AW-1:0] A_LO = AW'(OP_A_ADDR);
    localparam logic [AW-1:0] A_HI = AW'(OP_A_ADDR + 1);
    localparam logic [AW-1:0] B_LO = AW'(OP_B_ADDR);
    localparam logic [AW-1:0] B_HI = AW'(OP_B_ADDR + 1);
    localparam logic [AW-1:0] R_LO = AW'(RES_ADDR);
    localparam logic [AW-1:0] R_HI = AW'(RES_ADDR + 1);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, ALIGN, SHIFT, ADD, NORM, WR_LO, WR_HI, DONE
    } state_t;

    state_t state, state_nxt;

    // Operand B's sign is never used, so only its low 15 bits are kept.
    logic [15:0] op_a;
    logic [14:0] op_b;
    logic        sign_a;
    logic [4:0]  exp_a;
    logic [10:0] mant_a;
    logic [10:0] mant_b;
    logic [3:0]  shift_cnt;
    logic [11:0] sum;
    logic [15:0] result;

    // Normalise a 12-bit mantissa sum. The result saturates to infinity
    // once the exponent reaches 31.
    function automatic logic [15:0] pack_result(input logic        s,
                                                input logic [4:0]  e,
                                                input logic [11:0] sm);
        logic [5:0] e_n;
        logic [9:0] frac;
        if (sm[11]) begin
            frac = sm[10:1];
            e_n  = {1'b0, e} + 6'd1;
        end else begin
            frac = sm[9:0];
            e_n  = {1'b0, e};
        end
        if (e_n >= 6'd31)
            pack_result = {s, 5'h1F, 10'h000};
        else
            pack_result = {s, e_n[4:0], frac};
    endfunction

    // Alignment decode from the raw operand registers. The hidden bit is set
    // for any non-zero exponent.
    logic [4:0]  exp_op_a, exp_op_b, exp_big, exp_small, exp_diff;
    logic [10:0] mant_op_a, mant_op_b;
    logic        b_larger;
    logic [3:0]  align_cnt;

    always_comb begin
        exp_op_a  = op_a[14:10];
        exp_op_b  = op_b[14:10];
        mant_op_a = {|op_a[14:10], op_a[9:0]};
        mant_op_b = {|op_b[14:10], op_b[9:0]};
        b_larger  = exp_op_b > exp_op_a;
        exp_big   = b_larger ? exp_op_b : exp_op_a;
        exp_small = b_larger ? exp_op_a : exp_op_b;
        exp_diff  = exp_big - exp_small;
        // Beyond 11 places the smaller mantissa is entirely shifted out.
        align_cnt = (exp_diff > 5'd11) ? 4'd11 : exp_diff[3:0];
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---- next state and memory-port decode ----
    always_comb begin
        state_nxt   = state;
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RD0;
            end
            RD0: begin
                mem_addr  = A_LO;
                state_nxt = RD1;
            end
            RD1: begin
                mem_addr  = A_HI;
                state_nxt = RD2;
            end
            RD2: begin
                mem_addr  = B_LO;
                state_nxt = RD3;
            end
            RD3: begin
                mem_addr  = B_HI;
                state_nxt = ALIGN;
            end
            ALIGN: begin
                state_nxt = (align_cnt == 4'd0) ? ADD : SHIFT;
            end
            SHIFT: begin
                // The count is non-zero on entry, so the last shift happens at 1.
                if (shift_cnt == 4'd1) state_nxt = ADD;
            end
            ADD:  state_nxt = NORM;
            NORM: state_nxt = WR_LO;
            WR_LO: begin
                mem_addr    = R_LO;
                mem_wr_data = result[7:0];
                mem_wr_en   = ~reset;   // never write in a reset cycle
                state_nxt   = WR_HI;
            end
            WR_HI: begin
                mem_addr    = R_HI;
                mem_wr_data = result[15:8];
                mem_wr_en   = ~reset;
                state_nxt   = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RD0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- operand capture, alignment, add and normalise ----
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            sign_a    <= 1'b0;
            exp_a     <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            shift_cnt <= '0;
            sum       <= '0;
            result    <= '0;
        end else begin
            case (state)
                RD0: op_a[7:0]   <= mem_rd_data;
                RD1: op_a[15:8]  <= mem_rd_data;
                RD2: op_b[7:0]   <= mem_rd_data;
                RD3: op_b[14:8]  <= mem_rd_data[6:0];
                ALIGN: begin
                    sign_a    <= op_a[15];
                    exp_a     <= exp_big;
                    mant_a    <= b_larger ? mant_op_b : mant_op_a;
                    mant_b    <= b_larger ? mant_op_a : mant_op_b;
                    shift_cnt <= align_cnt;
                end
                SHIFT: begin
                    mant_b    <= mant_b >> 1;
                    shift_cnt <= shift_cnt - 4'd1;
                end
                ADD:  sum    <= {1'b0, mant_a} + {1'b0, mant_b};
                NORM: result <= pack_result(sign_a, exp_a, sum);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fltadd_sequencer.sv
module tb_fltadd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;

    fltadd_sequencer #(
        .OP_A_ADDR(8), .OP_B_ADDR(10), .RES_ADDR(12), .AW(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
    );

    always #5 clk = ~clk;

    // Byte memory. The DUT and the bench both write it, only from this block.
    logic [7:0] mem [0:255];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;
    int         wr_total = 0;
    logic [7:0] wr_log [0:1023];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            if (wr_total < 1024) wr_log[wr_total] <= mem_addr;
            wr_total <= wr_total + 1;
        end
        if (tb_we) mem[tb_addr] <= tb_data;
    end

    assign mem_rd_data = mem[mem_addr];

    int passed = 0;
    int total  = 0;

    // Reference model: plain integer arithmetic on the half-precision fields.
    function automatic int ref_shift(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, d;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        d  = (ea > eb) ? ea - eb : eb - ea;
        return (d > 11) ? 11 : d;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, t, s, e, f;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = ((ea != 0) ? 1024 : 0) + int'(a[9:0]);
        mb = ((eb != 0) ? 1024 : 0) + int'(b[9:0]);
        if (eb > ea) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
        end
        mb = mb >> ref_shift(a, b);
        s  = ma + mb;
        if (s >= 2048) begin
            e = ea + 1;
            f = (s / 2) % 1024;
        end else begin
            e = ea;
            f = s % 1024;
        end
        if (e >= 31) return {a[15], 5'h1F, 10'h000};
        return {a[15], e[4:0], f[9:0]};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Loads operands, starts one add and gathers what the DUT did. Latency is
    // the number of clock edges from the cycle start is presented until done
    // is seen. With corrupt set, operand A's high byte is overwritten after
    // the read phase.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit hold, input bit corrupt,
                          output logic [15:0] res, output int lat, output int nwr,
                          output logic [7:0] wa0, output logic [7:0] wa1,
                          output logic done_c1, output bit timed_out);
        int w0;
        bit seen;
        poke(8'd8,  a[7:0]);
        poke(8'd9,  a[15:8]);
        poke(8'd10, b[7:0]);
        poke(8'd11, b[15:8]);
        w0      = wr_total;
        start   = 1'b1;
        lat     = 0;
        seen    = 1'b0;
        done_c1 = 1'bx;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (lat == 1) done_c1 = done;
            if (corrupt && lat == 6) begin
                tb_addr = 8'd9;
                tb_data = a[15:8] ^ 8'h55;
                tb_we   = 1'b1;
            end else begin
                tb_we = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        start     = 1'b0;
        tb_we     = 1'b0;
        timed_out = !seen;
        res       = {mem[13], mem[12]};
        nwr       = wr_total - w0;
        wa0       = wr_log[w0];
        wa1       = wr_log[w0 + 1];
    endtask

    task automatic run_and_check(input string name, input logic [15:0] a,
                                 input logic [15:0] b, input bit hold,
                                 input bit corrupt, input bit use_lit,
                                 input logic [15:0] lit);
        logic [15:0] res, exp_res;
        int lat, exp_lat, nwr;
        logic [7:0] wa0, wa1;
        logic done_c1;
        bit to;
        exp_res = ref_add(a, b);
        exp_lat = 10 + ref_shift(a, b);
        run_op(a, b, hold, corrupt, res, lat, nwr, wa0, wa1, done_c1, to);
        total++;
        if (to !== 1'b0) $display("FAIL %s timeout: done never rose within 60 cycles", name);
        else passed++;
        total++;
        if (done_c1 !== 1'b0) $display("FAIL %s done_drop: done=%b after start edge, want 0", name, done_c1);
        else passed++;
        total++;
        if (res !== exp_res) $display("FAIL %s result: got %h want %h (a=%h b=%h)", name, res, exp_res, a, b);
        else passed++;
        if (use_lit) begin
            total++;
            if (res !== lit) $display("FAIL %s result_lit: got %h want %h", name, res, lit);
            else passed++;
        end
        total++;
        if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        else passed++;
        total++;
        if (nwr != 2) $display("FAIL %s write_count: got %0d want 2", name, nwr);
        else passed++;
        total++;
        if (wa0 !== 8'd12 || wa1 !== 8'd13)
            $display("FAIL %s write_addr: got %0d,%0d want 12,13", name, wa0, wa1);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tb_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done);
        else passed++;
        total++;
        if (mem_wr_en !== 1'b0) $display("FAIL reset wr_en: got %b want 0", mem_wr_en);
        else passed++;
        total++;
        if (mem_addr !== 8'd0) $display("FAIL reset addr: got %h want 00", mem_addr);
        else passed++;
        total++;
        if (mem_wr_data !== 8'd0) $display("FAIL reset wr_data: got %h want 00", mem_wr_data);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_equal_exp();
        run_and_check("equal_exp", 16'h1A04, 16'h1A04, 1'b0, 1'b0, 1'b1, 16'h1E04);
    endtask

    task automatic test_swap();
        run_and_check("swap", 16'h4200, 16'h5604, 1'b0, 1'b0, 1'b1, 16'h5634);
    endtask

    task automatic test_large_diff();
        run_and_check("large_diff", 16'h1A04, 16'h6604, 1'b0, 1'b0, 1'b1, 16'h6604);
    endtask

    task automatic test_overflow();
        run_and_check("overflow", 16'h7A00, 16'h7A00, 1'b0, 1'b0, 1'b1, 16'h7C00);
        run_and_check("zeros", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000);
    endtask

    task automatic test_reset_mid_op();
        int w0, done_cycles;
        poke(8'd12, 8'hAA);
        poke(8'd13, 8'hAA);
        poke(8'd8,  8'h04);
        poke(8'd9,  8'h1A);
        poke(8'd10, 8'h04);
        poke(8'd11, 8'h66);
        w0    = wr_total;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Seven more edges puts the DUT well inside its 11-cycle shift phase.
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || mem_wr_en !== 1'b0)
            $display("FAIL midreset outputs: done=%b wr_en=%b want 0,0", done, mem_wr_en);
        else passed++;
        reset = 1'b0;
        done_cycles = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) done_cycles++;
        end
        total++;
        if (done_cycles != 0) $display("FAIL midreset idle: done high %0d cycles want 0", done_cycles);
        else passed++;
        total++;
        if (wr_total != w0) $display("FAIL midreset writes: got %0d want 0", wr_total - w0);
        else passed++;
        total++;
        if (mem[12] !== 8'hAA || mem[13] !== 8'hAA)
            $display("FAIL midreset bytes: got %h%h want AAAA", mem[13], mem[12]);
        else passed++;
        run_and_check("after_reset", 16'h1A04, 16'h1A04, 1'b0, 1'b0, 1'b1, 16'h1E04);
    endtask

    task automatic test_handshake();
        run_and_check("start_held", 16'h4200, 16'h5604, 1'b1, 1'b0, 1'b1, 16'h5634);
        // The DUT is now in DONE; a new start must restart it.
        run_and_check("restart_from_done", 16'h4A04, 16'h4204, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_mem_after_read();
        run_and_check("mem_after_read", 16'h1A04, 16'h6604, 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = {s, 5'($urandom_range(0, 31)), 10'($urandom)};
            b = {s, 5'($urandom_range(0, 31)), 10'($urandom)};
            run_and_check("random", a, b, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        tb_we   = 1'b0;
        tb_addr = 8'd0;
        tb_data = 8'd0;
        @(negedge clk);
        test_reset();
        test_equal_exp();
        test_swap();
        test_large_diff();
        test_overflow();
        test_reset_mid_op();
        test_handshake();
        test_mem_after_read();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
